mram_burst_arbiter: RTL and testbench

- Frame-level scheduler in front of the MRAM control_module.
- Two requesters (port 0, port 1) submit read or write bursts. The block arbitrates between them round-robin and drives the 3-bit read_write_sel for each 23-cycle MRAM frame.
- It keeps a frame counter in lockstep with control_module and changes the command only on frame boundaries.
- It tags the frames in which read data returns, so the shared deserialiser output can be routed to the correct requester.

---
 rtl/mram_burst_arbiter.sv | 137 +++++++++++++
 tb/tb_mram_burst_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mram_burst_arbiter.sv
// Frame-level round-robin scheduler in front of the MRAM control_module.
// Issues one read_write_sel command per 23-cycle frame and tags read-return frames.
//
// state | meaning
// IDLE  | no burst owns the bus, read_write_sel = NOP, arbitrate at frame end
// BURST | granted requester owns every frame until beats_left reaches zero
// DRAIN | one NOP frame after a read so its return data is not overrun by a write
module mram_burst_arbiter #(
    parameter int FRAME_LEN = 23,
    parameter int LEN_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_wr,
    input  logic [1:0]       req0_bytes,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_wr,
    input  logic [1:0]       req1_bytes,
    input  logic [LEN_W-1:0] req1_len,
    output logic [2:0]       read_write_sel,
    output logic             frame_start,
    output logic             beat_adv,
    output logic [1:0]       grant,
    output logic             rd_ret_valid,
    output logic             rd_ret_id,
    output logic             busy
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   frame_cnt;
    logic               wr_q;
    logic [LEN_W-1:0]   beats_left;
    logic               id_q;
    logic               rr_ptr;
    logic               last_rd;

    logic               frame_end;
    logic               last_beat;
    logic               arb_slot;
    logic               pref;
    logic               win_any;
    logic               win_id;
    logic               win_wr;
    logic [1:0]         win_bytes_raw;
    logic [1:0]         win_bytes;
    logic [LEN_W-1:0]   win_len;
    logic               hold_off;
    logic               accept;

    assign frame_end = (frame_cnt == LAST_CNT);
    assign last_beat = (state == BURST) && (beats_left == '0);
    assign arb_slot  = frame_end && ((state != BURST) || last_beat);

    // rr_ptr holds the port preferred on a tie; a finishing burst hands preference
    // to the other port in the same cycle so back-to-back ties alternate.
    assign pref          = last_beat ? ~id_q : rr_ptr;
    assign win_any       = req0_valid | req1_valid;
    assign win_id        = (req0_valid && req1_valid) ? pref : req1_valid;
    assign win_wr        = win_id ? req1_wr : req0_wr;
    assign win_bytes_raw = win_id ? req1_bytes : req0_bytes;
    assign win_bytes     = (win_bytes_raw == 2'b00) ? 2'b11 : win_bytes_raw;
    assign win_len       = win_id ? req1_len : req0_len;

    // A read must never be followed directly by a write frame.
    assign hold_off = ((state == BURST) && !wr_q && (!win_any || win_wr))
                   || ((state == IDLE) && last_rd && win_any && win_wr);
    assign accept   = arb_slot && win_any && !hold_off;

    assign req0_ready  = accept && !win_id;
    assign req1_ready  = accept && win_id;
    assign beat_adv    = (state == BURST) && frame_end;
    assign frame_start = (frame_cnt == '0);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt      <= '0;
            state          <= IDLE;
            wr_q           <= 1'b0;
            beats_left     <= '0;
            id_q           <= 1'b0;
            rr_ptr         <= 1'b0;
            last_rd        <= 1'b0;
            read_write_sel <= 3'b000;
            grant          <= 2'b00;
            rd_ret_valid   <= 1'b0;
            rd_ret_id      <= 1'b0;
        end else begin
            frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;

            if (frame_end) begin
                // A read frame's data shifts out during the following frame.
                rd_ret_valid <= !read_write_sel[0] && (read_write_sel[2:1] != 2'b00);
                if (!read_write_sel[0] && (read_write_sel[2:1] != 2'b00))
                    rd_ret_id <= id_q;

                if (state == BURST) begin
                    if (!last_beat)
                        beats_left <= beats_left - 1'b1;
                    else
                        rr_ptr <= ~id_q;
                end

                if (arb_slot) begin
                    if (accept) begin
                        state          <= BURST;
                        wr_q           <= win_wr;
                        beats_left     <= win_len;
                        id_q           <= win_id;
                        last_rd        <= !win_wr;
                        grant          <= win_id ? 2'b10 : 2'b01;
                        read_write_sel <= {win_bytes, win_wr};
                    end else if (hold_off) begin
                        state          <= DRAIN;
                        last_rd        <= 1'b0;
                        grant          <= 2'b00;
                        read_write_sel <= 3'b000;
                    end else begin
                        state          <= IDLE;
                        grant          <= 2'b00;
                        read_write_sel <= 3'b000;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mram_burst_arbiter.sv
// Frame-by-frame directed bench for mram_burst_arbiter: a table of per-frame
// inputs and expected outputs, plus hand sequences for len=15 and mid-burst reset.
module tb_mram_burst_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_wr;
    logic [1:0] req0_bytes;
    logic [3:0] req0_len;
    logic       req1_valid, req1_ready, req1_wr;
    logic [1:0] req1_bytes;
    logic [3:0] req1_len;
    logic [2:0] read_write_sel;
    logic       frame_start, beat_adv, rd_ret_valid, rd_ret_id, busy;
    logic [1:0] grant;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mram_burst_arbiter #(.FRAME_LEN(23), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_bytes(req0_bytes), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_bytes(req1_bytes), .req1_len(req1_len),
        .read_write_sel(read_write_sel), .frame_start(frame_start),
        .beat_adv(beat_adv), .grant(grant), .rd_ret_valid(rd_ret_valid),
        .rd_ret_id(rd_ret_id), .busy(busy)
    );

    typedef struct {
        logic       v0, w0;
        logic [1:0] b0;
        logic [3:0] l0;
        logic       v1, w1;
        logic [1:0] b1;
        logic [3:0] l1;
        logic [2:0] sel;
        logic [1:0] gnt;
        logic       bsy, rv, rid, r0, r1, bt;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(int v0, int w0, int b0, int l0, int v1, int w1, int b1, int l1,
                                int sel, int gnt, int bsy, int rv, int rid, int r0, int r1, int bt);
        vec_t r;
        r.v0 = 1'(v0); r.w0 = 1'(w0); r.b0 = 2'(b0); r.l0 = 4'(l0);
        r.v1 = 1'(v1); r.w1 = 1'(w1); r.b1 = 2'(b1); r.l1 = 4'(l1);
        r.sel = 3'(sel); r.gnt = 2'(gnt); r.bsy = 1'(bsy); r.rv = 1'(rv);
        r.rid = 1'(rid); r.r0 = 1'(r0); r.r1 = 1'(r1); r.bt = 1'(bt);
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_wr = v.w0; req0_bytes = v.b0; req0_len = v.l0;
        req1_valid = v.v1; req1_wr = v.w1; req1_bytes = v.b1; req1_len = v.l1;
    endtask

    // Entered on the negedge where frame_cnt == 0; leaves on the next frame's cnt 0.
    task automatic run_frame(input vec_t v, input int idx);
        check($sformatf("f%0d frame_start", idx), frame_start, 1);
        drive(v);
        step(5);
        check($sformatf("f%0d sel", idx), read_write_sel, v.sel);
        check($sformatf("f%0d grant", idx), grant, v.gnt);
        check($sformatf("f%0d busy", idx), busy, v.bsy);
        check($sformatf("f%0d rd_ret_valid", idx), rd_ret_valid, v.rv);
        if (v.rv) check($sformatf("f%0d rd_ret_id", idx), rd_ret_id, v.rid);
        check($sformatf("f%0d mid readies", idx), {req1_ready, req0_ready}, 0);
        check($sformatf("f%0d mid frame_start", idx), frame_start, 0);
        step(17);
        check($sformatf("f%0d req0_ready", idx), req0_ready, v.r0);
        check($sformatf("f%0d req1_ready", idx), req1_ready, v.r1);
        check($sformatf("f%0d beat_adv", idx), beat_adv, v.bt);
        step(1);
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0);
        //           v0 w0 b0 l0  v1 w1 b1 l1  sel gnt bsy rv rid  r0 r1 bt
        tbl[0]  = mk(1, 1, 3, 2,  0, 0, 0, 0,  0,  0,  0,  0, 0,   1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  7,  1,  1,  0, 0,   0, 0, 1);
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = idle;
        tbl[5]  = mk(0, 0, 0, 0,  1, 0, 1, 0,  0,  0,  0,  0, 0,   0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  2,  2,  1,  0, 0,   0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,  0,  1,  1, 1,   0, 0, 0);
        tbl[8]  = idle;
        tbl[9]  = mk(1, 1, 2, 0,  1, 1, 1, 0,  0,  0,  0,  0, 0,   1, 0, 0);
        tbl[10] = mk(1, 1, 2, 0,  1, 1, 1, 0,  5,  1,  1,  0, 0,   0, 1, 1);
        tbl[11] = mk(1, 1, 2, 0,  1, 1, 1, 0,  3,  2,  1,  0, 0,   1, 0, 1);
        tbl[12] = mk(1, 1, 2, 0,  1, 1, 1, 0,  5,  1,  1,  0, 0,   0, 1, 1);
        tbl[13] = mk(0, 0, 0, 0,  0, 0, 0, 0,  3,  2,  1,  0, 0,   0, 0, 1);
        tbl[14] = idle;
        tbl[15] = mk(1, 0, 3, 1,  0, 0, 0, 0,  0,  0,  0,  0, 0,   1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,  1, 1, 3, 0,  6,  1,  1,  0, 0,   0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0,  1, 1, 3, 0,  6,  1,  1,  1, 0,   0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0,  1, 1, 3, 0,  0,  0,  1,  1, 0,   0, 1, 0);
        tbl[19] = mk(0, 0, 0, 0,  0, 0, 0, 0,  7,  2,  1,  0, 0,   0, 0, 1);
        tbl[20] = idle;
        tbl[21] = mk(1, 0, 1, 0,  0, 0, 0, 0,  0,  0,  0,  0, 0,   1, 0, 0);
        tbl[22] = mk(0, 0, 0, 0,  1, 0, 2, 0,  2,  1,  1,  0, 0,   0, 1, 1);
        tbl[23] = mk(0, 0, 0, 0,  0, 0, 0, 0,  4,  2,  1,  1, 0,   0, 0, 1);
        tbl[24] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,  0,  1,  1, 1,   0, 0, 0);
        tbl[25] = idle;

        rst_n = 1'b0;
        drive(idle);
        step(3);
        check("rst sel", read_write_sel, 0);
        check("rst grant", grant, 0);
        check("rst busy", busy, 0);
        check("rst frame_start", frame_start, 1);
        check("rst readies", {req1_ready, req0_ready}, 0);
        check("rst beat_adv", beat_adv, 0);
        check("rst rd_ret", {rd_ret_valid, rd_ret_id}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) run_frame(tbl[i], i);

        // bytes 00 is promoted to 11; len 15 runs 16 frames without wrapping.
        run_frame(mk(1,1,0,15, 0,0,0,0, 0,0,0,0,0, 1,0,0), 26);
        for (int i = 0; i < 16; i++)
            run_frame(mk(0,0,0,0, 0,0,0,0, 7,1,1,0,0, 0,0,1), 27 + i);
        run_frame(idle, 43);

        // Reset in the middle of a burst frame.
        drive(mk(1,1,3,3, 0,0,0,0, 0,0,0,0,0, 0,0,0));
        step(22);
        check("rb req0_ready", req0_ready, 1);
        step(1);
        drive(idle);
        step(10);
        check("rb grant before reset", grant, 1);
        rst_n = 1'b0;
        #1;
        check("rb sel", read_write_sel, 0);
        check("rb grant", grant, 0);
        check("rb busy", busy, 0);
        check("rb frame_start", frame_start, 1);
        step(2);
        rst_n = 1'b1;
        check("rb release frame_start", frame_start, 1);
        check("rb release grant", grant, 0);
        run_frame(idle, 44);
        run_frame(idle, 45);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
